// File: rtl/host_mem_ctrl.sv
// Single-cache-line bridge between the miner core's word port and the AFU DMA channels.
// Reads stream one host line out as words; writes gather words into one host line.
module host_mem_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_init,
    input  logic [1:0]            mem_op,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [ADDR_WIDTH-1:0] address_offset,
    input  logic [WORD_WIDTH-1:0] cpu_in,
    input  logic                  cpu_in_valid,
    output logic [WORD_WIDTH-1:0] cpu_out,
    output logic                  rd_valid,
    output logic                  ready,
    output logic                  tx_done,
    input  logic                  host_rd_ready,
    input  logic                  host_wr_ready,
    input  logic [LINE_WIDTH-1:0] host_data_bus_read_in,
    output logic [LINE_WIDTH-1:0] host_data_bus_write_out,
    output logic [ADDR_WIDTH-1:0] corrected_address,
    output logic                  host_re,
    output logic                  host_we,
    output logic                  host_rgo,
    output logic                  host_wgo,
    output logic [2:0]            dbg_state
);
    localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
    localparam int CW    = $clog2(WORDS);
    localparam int LSB   = $clog2(LINE_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RD_GO      = 3'd1;
    localparam logic [2:0] S_RD_WAIT    = 3'd2;
    localparam logic [2:0] S_RD_STREAM  = 3'd3;
    localparam logic [2:0] S_WR_COLLECT = 3'd4;
    localparam logic [2:0] S_WR_GO      = 3'd5;
    localparam logic [2:0] S_WR_WAIT    = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    logic [2:0]            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Handshakes: every DMA strobe is a one-cycle level decoded from state;
    // host_re/host_we additionally require the channel's ready in that same cycle.
    always_comb begin
        ready    = armed_q && (state_q == S_IDLE);
        host_rgo = (state_q == S_RD_GO);
        host_re  = (state_q == S_RD_WAIT) && host_rd_ready;
        rd_valid = (state_q == S_RD_STREAM);
        host_wgo = (state_q == S_WR_GO);
        host_we  = (state_q == S_WR_WAIT) && host_wr_ready;
        tx_done  = (state_q == S_DONE);
        cpu_out  = rd_valid ? line_q[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] : '0;
        host_data_bus_write_out = wr_q;
        corrected_address       = addr_q;
        dbg_state               = state_q;
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q | host_init;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (ready && (mem_op == 2'b01 || mem_op == 2'b10)) begin
                    // Line index to byte address: top LSB bits of the index fall off.
                    addr_d  = address_offset + {cpu_addr[ADDR_WIDTH-LSB-1:0], {LSB{1'b0}}};
                    cnt_d   = '0;
                    state_d = (mem_op == 2'b01) ? S_RD_GO : S_WR_COLLECT;
                end
            end
            S_RD_GO: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (host_rd_ready) begin
                    line_d  = host_data_bus_read_in;
                    cnt_d   = '0;
                    state_d = S_RD_STREAM;
                end
            end
            S_RD_STREAM: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_WR_COLLECT: begin
                if (cpu_in_valid) begin
                    line_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = cpu_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_WR_GO;
                end
            end
            S_WR_GO: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (host_wr_ready) begin
                    wr_d    = line_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            line_q  <= '0;
            wr_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_host_mem_ctrl.sv
// Directed bench for host_mem_ctrl: arming, reads with and without stall,
// gapped write, address wrap and asynchronous reset during streaming.
module tb_host_mem_ctrl;
    localparam int AW = 64;
    localparam int LW = 512;
    localparam int WW = 32;

    logic          clk;
    logic          rst;
    logic          host_init;
    logic [1:0]    mem_op;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] address_offset;
    logic [WW-1:0] cpu_in;
    logic          cpu_in_valid;
    logic [WW-1:0] cpu_out;
    logic          rd_valid;
    logic          ready;
    logic          tx_done;
    logic          host_rd_ready;
    logic          host_wr_ready;
    logic [LW-1:0] host_data_bus_read_in;
    logic [LW-1:0] host_data_bus_write_out;
    logic [AW-1:0] corrected_address;
    logic          host_re;
    logic          host_we;
    logic          host_rgo;
    logic          host_wgo;
    logic [2:0]    dbg_state;

    host_mem_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .WORD_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .host_init(host_init), .mem_op(mem_op),
        .cpu_addr(cpu_addr), .address_offset(address_offset),
        .cpu_in(cpu_in), .cpu_in_valid(cpu_in_valid),
        .cpu_out(cpu_out), .rd_valid(rd_valid), .ready(ready), .tx_done(tx_done),
        .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
        .host_data_bus_read_in(host_data_bus_read_in),
        .host_data_bus_write_out(host_data_bus_write_out),
        .corrected_address(corrected_address),
        .host_re(host_re), .host_we(host_we), .host_rgo(host_rgo), .host_wgo(host_wgo),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] got_q[$];

    int m_rgo, m_wgo, m_re, m_we, m_overlap, m_re_bad, m_we_bad;
    int m_rgo_cyc, m_wgo_cyc, m_re_cyc, m_we_cyc, m_done_cyc;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: present an op while ready; returns #1 after the accepting edge
    task automatic start_op(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] offs);
        check("ready_before_op", LW'(ready), LW'(1));
        mem_op = op;
        cpu_addr = addr;
        address_offset = offs;
        @(posedge clk); #1;
        mem_op = 2'b00;
        cpu_addr = '0;
    endtask

    // driver + monitor for one op; cycle 0 is the first cycle after accept
    task automatic run_op(input bit is_wr, input int rd_delay, input int wr_delay, input int max_cyc);
        int wr_idx;
        int n_strb;
        wr_idx = 0;
        m_rgo = 0; m_wgo = 0; m_re = 0; m_we = 0; m_overlap = 0; m_re_bad = 0; m_we_bad = 0;
        m_rgo_cyc = -1; m_wgo_cyc = -1; m_re_cyc = -1; m_we_cyc = -1; m_done_cyc = -1;
        got_q.delete();
        for (int i = 0; i < max_cyc; i++) begin
            host_rd_ready = (i >= 1 + rd_delay);
            host_wr_ready = (i >= wr_delay);
            if (is_wr && wr_idx < 16 && (i % 3) != 2) begin
                cpu_in_valid = 1'b1;
                cpu_in = WW'(32'hA0 + wr_idx);
                wr_idx++;
            end else begin
                cpu_in_valid = 1'b0;
                cpu_in = '0;
            end
            #1;
            n_strb = int'(host_rgo) + int'(host_wgo) + int'(host_re) + int'(host_we);
            if (n_strb > 1) m_overlap++;
            if (host_rgo) begin m_rgo++; m_rgo_cyc = i; end
            if (host_wgo) begin m_wgo++; m_wgo_cyc = i; end
            if (host_re) begin m_re++; m_re_cyc = i; end
            if (host_we) begin m_we++; m_we_cyc = i; end
            if (host_re && !host_rd_ready) m_re_bad++;
            if (host_we && !host_wr_ready) m_we_bad++;
            if (rd_valid) got_q.push_back(cpu_out);
            if (tx_done) begin
                m_done_cyc = i;
                break;
            end
            @(posedge clk); #1;
        end
        check("op_completed_in_budget", LW'(m_done_cyc >= 0), LW'(1));
        host_rd_ready = 1'b0;
        host_wr_ready = 1'b0;
        cpu_in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // scoreboard: compare streamed words against exp_q
    task automatic score_read(input string tag);
        check({tag, "_word_count"}, LW'(got_q.size()), LW'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_word"}, LW'(got_q.pop_front()), LW'(exp_q.pop_front()));
    endtask

    task automatic fill_exp_read;
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(WW'(k));
    endtask

    logic [LW-1:0] exp_line;

    initial begin
        rst = 1'b1;
        host_init = 1'b0;
        mem_op = 2'b00;
        cpu_addr = '0;
        address_offset = '0;
        cpu_in = '0;
        cpu_in_valid = 1'b0;
        host_rd_ready = 1'b0;
        host_wr_ready = 1'b0;
        for (int k = 0; k < 16; k++) host_data_bus_read_in[k*WW +: WW] = WW'(k);

        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", LW'(ready), LW'(0));
        check("rst_state", LW'(dbg_state), LW'(0));
        check("rst_addr", LW'(corrected_address), LW'(0));
        check("rst_write_out", host_data_bus_write_out, LW'(0));
        check("rst_strobes", LW'({host_rgo, host_wgo, host_re, host_we, rd_valid, tx_done}), LW'(0));
        check("rst_cpu_out", LW'(cpu_out), LW'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // op before host_init is ignored
        mem_op = 2'b01;
        cpu_addr = 64'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("unarmed_ready", LW'(ready), LW'(0));
            check("unarmed_rgo", LW'(host_rgo), LW'(0));
            check("unarmed_state", LW'(dbg_state), LW'(0));
            @(posedge clk); #1;
        end
        mem_op = 2'b00;

        host_init = 1'b1;
        @(posedge clk); #1;
        host_init = 1'b0;
        check("armed_ready", LW'(ready), LW'(1));

        // reserved op leaves the controller idle
        mem_op = 2'b11;
        @(posedge clk); #1;
        mem_op = 2'b00;
        check("reserved_op_state", LW'(dbg_state), LW'(0));
        check("reserved_op_ready", LW'(ready), LW'(1));

        // plain read
        start_op(2'b01, 64'd3, 64'h1000);
        check("rd_addr", LW'(corrected_address), LW'(64'h10C0));
        check("rd_state_go", LW'(dbg_state), LW'(1));
        fill_exp_read();
        run_op(1'b0, 0, 0, 60);
        check("rd_rgo_count", LW'(m_rgo), LW'(1));
        check("rd_rgo_cyc", LW'(m_rgo_cyc), LW'(0));
        check("rd_re_count", LW'(m_re), LW'(1));
        check("rd_re_cyc", LW'(m_re_cyc), LW'(1));
        check("rd_done_cyc", LW'(m_done_cyc), LW'(18));
        check("rd_no_wr_strobes", LW'(m_wgo + m_we), LW'(0));
        check("rd_overlap", LW'(m_overlap), LW'(0));
        score_read("rd");
        check("rd_back_idle", LW'(dbg_state), LW'(0));
        check("rd_addr_held", LW'(corrected_address), LW'(64'h10C0));

        // read with host_rd_ready held low for 10 cycles
        start_op(2'b01, 64'd5, 64'h2000);
        check("stall_addr", LW'(corrected_address), LW'(64'h2140));
        fill_exp_read();
        run_op(1'b0, 10, 0, 60);
        check("stall_re_count", LW'(m_re), LW'(1));
        check("stall_re_cyc", LW'(m_re_cyc), LW'(11));
        check("stall_re_without_ready", LW'(m_re_bad), LW'(0));
        check("stall_done_cyc", LW'(m_done_cyc), LW'(28));
        score_read("stall");

        // gapped write, host_wr_ready rises late
        start_op(2'b10, 64'd2, 64'h4000);
        check("wr_addr", LW'(corrected_address), LW'(64'h4080));
        check("wr_state_collect", LW'(dbg_state), LW'(4));
        run_op(1'b1, 0, 27, 60);
        check("wr_wgo_count", LW'(m_wgo), LW'(1));
        check("wr_wgo_cyc", LW'(m_wgo_cyc), LW'(23));
        check("wr_we_count", LW'(m_we), LW'(1));
        check("wr_we_cyc", LW'(m_we_cyc), LW'(27));
        check("wr_we_without_ready", LW'(m_we_bad), LW'(0));
        check("wr_done_cyc", LW'(m_done_cyc), LW'(28));
        check("wr_no_rd_strobes", LW'(m_rgo + m_re), LW'(0));
        check("wr_overlap", LW'(m_overlap), LW'(0));
        check("wr_word0", LW'(host_data_bus_write_out[31:0]), LW'(32'hA0));
        check("wr_word15", LW'(host_data_bus_write_out[511:480]), LW'(32'hAF));
        for (int k = 0; k < 16; k++) exp_line[k*WW +: WW] = WW'(32'hA0 + k);
        check("wr_line", host_data_bus_write_out, exp_line);

        // address wrap; write data must survive a read
        start_op(2'b01, 64'd1, 64'hFFFF_FFFF_FFFF_FFC0);
        check("wrap_addr", LW'(corrected_address), LW'(0));
        fill_exp_read();
        run_op(1'b0, 0, 0, 60);
        score_read("wrap");
        check("wr_line_held", host_data_bus_write_out, exp_line);

        // top index bits are dropped by the shift
        start_op(2'b01, 64'hFC00_0000_0000_0002, 64'h0);
        check("shift_drop_addr", LW'(corrected_address), LW'(64'h80));
        fill_exp_read();
        run_op(1'b0, 0, 0, 60);
        score_read("shift");

        // async reset in the middle of a stream
        start_op(2'b01, 64'd4, 64'h0);
        host_rd_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_rd_valid", LW'(rd_valid), LW'(1));
        check("pre_rst_word", LW'(cpu_out), LW'(2));
        #1;
        rst = 1'b1;
        #1;
        check("arst_rd_valid", LW'(rd_valid), LW'(0));
        check("arst_cpu_out", LW'(cpu_out), LW'(0));
        check("arst_ready", LW'(ready), LW'(0));
        check("arst_state", LW'(dbg_state), LW'(0));
        check("arst_addr", LW'(corrected_address), LW'(0));
        check("arst_write_out", host_data_bus_write_out, LW'(0));
        check("arst_strobes", LW'({host_rgo, host_wgo, host_re, host_we, tx_done}), LW'(0));
        #1;
        rst = 1'b0;
        host_rd_ready = 1'b0;
        mem_op = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("post_rst_ready", LW'(ready), LW'(0));
            check("post_rst_rgo", LW'(host_rgo), LW'(0));
        end
        mem_op = 2'b00;
        host_init = 1'b1;
        @(posedge clk); #1;
        host_init = 1'b0;
        check("rearmed_ready", LW'(ready), LW'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
